// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for receive-side monitors of the multiplexed,
// active-low 7-segment display bus.
//   - SEG_0..SEG_9 : full 8-bit patterns {a,b,c,d,e,f,g,dp}, with dp unlit (1)
//   - SEG_PAT      : the same ten patterns packed, indexed by digit value
//   - SEG_BLANK    : every segment off
//   - CODE_BLANK / CODE_INVALID : the decoder's non-digit result codes
//   - SEL_D0..SEL_D3 / SEL_NONE : active-low digit-select values
//   - seg_dec_t    : decoder result {code, blank, invalid}
//   - sel_low_count: number of select lines that are low
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam logic [7:0] SEG_0 = 8'h03;
   localparam logic [7:0] SEG_1 = 8'h9F;
   localparam logic [7:0] SEG_2 = 8'h25;
   localparam logic [7:0] SEG_3 = 8'h0D;
   localparam logic [7:0] SEG_4 = 8'h99;
   localparam logic [7:0] SEG_5 = 8'h49;
   localparam logic [7:0] SEG_6 = 8'h41;
   localparam logic [7:0] SEG_7 = 8'h1F;
   localparam logic [7:0] SEG_8 = 8'h01;
   localparam logic [7:0] SEG_9 = 8'h09;

   // SEG_PAT[k] is the pattern for digit value k.
   localparam logic [9:0][7:0] SEG_PAT = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                          SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

   localparam logic [7:0] SEG_BLANK    = 8'hFF;
   localparam logic [3:0] CODE_BLANK   = 4'hF;
   localparam logic [3:0] CODE_INVALID = 4'hE;

   // Digit selects are one-hot-cold: the single low bit names the digit.
   localparam logic [3:0] SEL_D0   = 4'b1110;
   localparam logic [3:0] SEL_D1   = 4'b1101;
   localparam logic [3:0] SEL_D2   = 4'b1011;
   localparam logic [3:0] SEL_D3   = 4'b0111;
   localparam logic [3:0] SEL_NONE = 4'b1111;

   typedef struct packed {
      logic [3:0] code;
      logic       blank;
      logic       invalid;
   } seg_dec_t;

   function automatic logic [2:0] sel_low_count(input logic [3:0] sel);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 4; i++) begin
         n = n + {2'b00, ~sel[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational decode of an active-low segment pattern (dp excluded) back to
// a 4-bit code.
//   i_seg [6:0] : segments {a,b,c,d,e,f,g}, active-low (bus bits seg[7:1])
//   o_dec       : {code, blank, invalid}
//                 digit patterns -> 0..9
//                 all segments off -> CODE_BLANK with blank set
//                 anything else  -> CODE_INVALID with invalid set
// -----------------------------------------------------------------------------
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_seg,
   output seg_dec_t   o_dec
);

   always_comb begin
      o_dec.code    = CODE_INVALID;
      o_dec.blank   = 1'b0;
      o_dec.invalid = 1'b1;
      if (i_seg == SEG_BLANK[7:1]) begin
         o_dec.code    = CODE_BLANK;
         o_dec.invalid = 1'b0;
         o_dec.blank   = 1'b1;
      end
      for (int k = 0; k < 10; k++) begin
         if (i_seg == SEG_PAT[k][7:1]) begin
            o_dec.code    = 4'(k);
            o_dec.invalid = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
// Loopback monitor for a multiplexed 4-digit active-low 7-segment bus. The
// bus is registered once, stability-filtered, and each stable digit dwell is
// decoded into a per-digit shadow. Once all four digits have been seen, the
// shadows are published as one word together with a frame_valid pulse.
//
// Parameters
//   STABLE_CYCLES  : identical samples needed before a digit is captured (>=1)
//   TIMEOUT_CYCLES : cycles without a completed frame before stale asserts
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   sel_in [3:0] : digit select, active-low, bit i low = digit i
//   seg_in [7:0] : segments {a,b,c,d,e,f,g,dp}, active-low
//   err_clr      : clears the sticky error flags
//   bcd_out[15:0]: digit3 at [15:12] .. digit0 at [3:0]
//   frame_valid  : one-cycle pulse when bcd_out updates
//   blank_mask   : bit i set = digit i was blank in the last frame
//   seg_err      : sticky, an undecodable pattern was captured
//   sel_err      : sticky, a stable select had two or more lines low
//   stale        : no frame within TIMEOUT_CYCLES
//   dp_out [3:0] : lit decimal points of the last frame (1 = lit); present
//                  only when SEG_DP_CAPTURE_EN is defined. Without that macro
//                  seg_in[0] plays no part at all, not even in stability.
// -----------------------------------------------------------------------------
module seg_scan_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  sel_in,
   input  logic [7:0]  seg_in,
   input  logic        err_clr,
   output logic [15:0] bcd_out,
   output logic        frame_valid,
   output logic [3:0]  blank_mask,
   output logic        seg_err,
   output logic        sel_err,
   output logic        stale
`ifdef SEG_DP_CAPTURE_EN
   ,output logic [3:0] dp_out
`endif
);

   localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
   localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES);

`ifdef SEG_DP_CAPTURE_EN
   localparam int IN_W = 12;
`else
   localparam int IN_W = 11;
`endif

   // ---------------------------------------------------------------- input
   logic [IN_W-1:0]   w_in;
   logic [IN_W-1:0]   r_in;
   logic [3:0]        w_sel_now;
   logic [6:0]        w_seg_now;

`ifdef SEG_DP_CAPTURE_EN
   assign w_in = {sel_in, seg_in};
`else
   logic w_unused_dp;
   assign w_in        = {sel_in, seg_in[7:1]};
   assign w_unused_dp = seg_in[0];
`endif

   assign w_sel_now = w_in[IN_W-1 -: 4];
   assign w_seg_now = w_in[IN_W-5 -: 7];

   // ------------------------------------------------------------ stability
   // r_stab counts how many consecutive samples of the current value r_in
   // holds. The capture decision is taken on the edge that loads the
   // STABLE_CYCLES-th identical sample, so it looks at the value arriving
   // now (equal to r_in unless this is the first sample of a new value).
   logic [STAB_W-1:0] r_stab;
   logic [STAB_W-1:0] w_stab_nxt;
   logic              w_chg;
   logic              w_qual;

   assign w_chg      = (w_in != r_in);
   assign w_stab_nxt = w_chg              ? STAB_W'(1) :
                       (r_stab == STAB_MAX) ? r_stab    : r_stab + STAB_W'(1);
   // Saturation keeps a long dwell to a single qualification; the w_chg
   // term covers STABLE_CYCLES==1, where the counter is already at max.
   assign w_qual     = (w_stab_nxt == STAB_MAX) && (w_chg || (r_stab != STAB_MAX));

   // --------------------------------------------------------------- decode
   seg_dec_t   w_dec;
   logic [2:0] w_low_cnt;
   logic       w_cap;
   logic       w_sel_bad;

   seg7_pattern_decode u_dec (
      .i_seg (w_seg_now),
      .o_dec (w_dec)
   );

   assign w_low_cnt = sel_low_count(w_sel_now);
   assign w_cap     = w_qual && (w_low_cnt == 3'd1);
   assign w_sel_bad = w_qual && (w_low_cnt >= 3'd2);

   // ----------------------------------------------------- shadows / frame
   logic [3:0][3:0] r_sh_code;
   logic [3:0]      r_sh_blank;
   logic [3:0]      r_seen;
   logic [3:0]      w_cap_mask;
   logic            w_frame;

   assign w_cap_mask = w_cap ? ~w_sel_now : 4'h0;
   assign w_frame    = (r_seen == 4'hF);

   logic [TO_W-1:0] r_to;
   logic [TO_W-1:0] w_to_nxt;

   assign w_to_nxt = w_frame           ? '0   :
                     (r_to == TO_MAX)  ? r_to : r_to + TO_W'(1);

`ifdef SEG_DP_CAPTURE_EN
   logic [3:0] r_sh_dp;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in        <= '1;
         r_stab      <= '0;
         r_sh_code   <= {4{CODE_BLANK}};
         r_sh_blank  <= 4'hF;
         r_seen      <= 4'h0;
         r_to        <= '0;
         bcd_out     <= 16'hFFFF;
         blank_mask  <= 4'hF;
         frame_valid <= 1'b0;
         seg_err     <= 1'b0;
         sel_err     <= 1'b0;
         stale       <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
         r_sh_dp     <= 4'h0;
         dp_out      <= 4'h0;
`endif
      end else begin
         r_in   <= w_in;
         r_stab <= w_stab_nxt;

         for (int i = 0; i < 4; i++) begin
            if (w_cap_mask[i]) begin
               r_sh_code[i]  <= w_dec.code;
               r_sh_blank[i] <= w_dec.blank;
`ifdef SEG_DP_CAPTURE_EN
               r_sh_dp[i]    <= ~w_in[0];
`endif
            end
         end

         // A capture on the publishing edge starts the next frame's mask.
         r_seen      <= (w_frame ? 4'h0 : r_seen) | w_cap_mask;
         frame_valid <= w_frame;
         if (w_frame) begin
            bcd_out    <= r_sh_code;
            blank_mask <= r_sh_blank;
`ifdef SEG_DP_CAPTURE_EN
            dp_out     <= r_sh_dp;
`endif
         end

         r_to <= w_to_nxt;
         if (w_frame)
            stale <= 1'b0;
         else if (w_to_nxt == TO_MAX)
            stale <= 1'b1;

         // Set takes priority over clear in the same cycle.
         seg_err <= (w_cap && w_dec.invalid) | (seg_err & ~err_clr);
         sel_err <= w_sel_bad | (sel_err & ~err_clr);
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
// Directed stimulus on the display bus. A behavioural model (run lengths of
// identical samples, table decode, per-digit shadow arrays) predicts every
// output each cycle; literal checks at key points pin the model's results.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

   localparam int S = 4;
   localparam int T = 100;

   logic        clk;
   logic        rst;
   logic [3:0]  sel_in;
   logic [7:0]  seg_in;
   logic        err_clr;
   logic [15:0] bcd_out;
   logic        frame_valid;
   logic [3:0]  blank_mask;
   logic        seg_err;
   logic        sel_err;
   logic        stale;
`ifdef SEG_DP_CAPTURE_EN
   logic [3:0]  dp_out;
`endif

   seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk         (clk),
      .rst         (rst),
      .sel_in      (sel_in),
      .seg_in      (seg_in),
      .err_clr     (err_clr),
      .bcd_out     (bcd_out),
      .frame_valid (frame_valid),
      .blank_mask  (blank_mask),
      .seg_err     (seg_err),
      .sel_err     (sel_err),
      .stale       (stale)
`ifdef SEG_DP_CAPTURE_EN
      ,.dp_out     (dp_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_err  = 0;
   int fv_cnt = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------- model
   logic [7:0]  pats [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                              8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
   logic        m_ready = 1'b0;
   logic [3:0]  m_code  [4];
   logic        m_blk   [4];
   logic        m_dp    [4];
   logic [3:0]  m_seen;
   logic [15:0] m_bcd;
   logic [3:0]  m_bmask;
   logic [3:0]  m_dpout;
   logic        m_fv, m_segerr, m_selerr, m_stale;
   int          m_to, m_run;
   logic [11:0] m_last;

   function automatic void mdec(input logic [7:0] g, output logic [3:0] c,
                                output logic b, output logic inv);
      logic [7:0] p;
      c = 4'hE; b = 1'b0; inv = 1'b1;
      if (g[7:1] == 7'h7F) begin
         c = 4'hF; b = 1'b1; inv = 1'b0;
      end
      for (int k = 0; k < 10; k++) begin
         p = pats[k];
         if (g[7:1] == p[7:1]) begin
            c = 4'(k); inv = 1'b0;
         end
      end
   endfunction

   initial begin
      logic [11:0] key;
      logic [3:0]  c;
      logic        b, inv, set_seg, set_sel;
      int          nlow, d;
      forever begin
         @(posedge clk);
`ifdef SEG_DP_CAPTURE_EN
         key = {sel_in, seg_in};
`else
         key = {1'b1, sel_in, seg_in[7:1]};
`endif
         if (rst) begin
            for (int i = 0; i < 4; i++) begin
               m_code[i] = 4'hF; m_blk[i] = 1'b1; m_dp[i] = 1'b0;
            end
            m_seen = 0; m_bcd = 16'hFFFF; m_bmask = 4'hF; m_dpout = 0;
            m_fv = 0; m_segerr = 0; m_selerr = 0; m_stale = 0;
            m_to = 0; m_run = 0; m_last = 12'hFFF;
            m_ready = 1'b1;
         end else begin
            m_fv = (m_seen == 4'hF);
            if (m_fv) begin
               m_bcd   = {m_code[3], m_code[2], m_code[1], m_code[0]};
               m_bmask = {m_blk[3], m_blk[2], m_blk[1], m_blk[0]};
               m_dpout = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
               m_seen  = 0; m_to = 0; m_stale = 0;
            end else begin
               if (m_to < T) m_to++;
               if (m_to == T) m_stale = 1;
            end
            if (key == m_last) m_run++;
            else m_run = 1;
            m_last = key;
            set_seg = 0; set_sel = 0;
            if (m_run == S) begin
               nlow = 0; d = 0;
               for (int i = 0; i < 4; i++)
                  if (!sel_in[i]) begin nlow++; d = i; end
               if (nlow == 1) begin
                  mdec(seg_in, c, b, inv);
                  m_code[d] = c; m_blk[d] = b; m_dp[d] = ~seg_in[0];
                  m_seen[d] = 1'b1;
                  set_seg = inv;
               end else if (nlow >= 2) begin
                  set_sel = 1;
               end
            end
            m_segerr = set_seg | (m_segerr & !err_clr);
            m_selerr = set_sel | (m_selerr & !err_clr);
         end
      end
   end

   // ----------------------------------------------------------- compare
   initial begin
      forever begin
         @(negedge clk);
         if (m_ready) begin
            chk("bcd_out",     bcd_out,          m_bcd);
            chk("blank_mask",  16'(blank_mask),  16'(m_bmask));
            chk("frame_valid", 16'(frame_valid), 16'(m_fv));
            chk("seg_err",     16'(seg_err),     16'(m_segerr));
            chk("sel_err",     16'(sel_err),     16'(m_selerr));
            chk("stale",       16'(stale),       16'(m_stale));
`ifdef SEG_DP_CAPTURE_EN
            chk("dp_out",      16'(dp_out),      16'(m_dpout));
`endif
            if (frame_valid === 1'b1) fv_cnt++;
         end
      end
   end

   // ---------------------------------------------------------- stimulus
   task automatic put(input logic [3:0] s, input logic [7:0] g, input int n);
      sel_in = s; seg_in = g;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic dig(input logic [3:0] s, input logic [7:0] g);
      put(s, g, 8);
      put(4'hF, 8'hFF, 2);
   endtask

   initial begin
      rst = 1'b1; sel_in = 4'hF; seg_in = 8'hFF; err_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_bcd",   bcd_out,         16'hFFFF);
      chk("rst_blank", 16'(blank_mask), 16'h000F);
      chk("rst_fv",    16'(frame_valid), 16'h0);
      chk("rst_flags", 16'({seg_err, sel_err, stale}), 16'h0);

      // no select activity: stale exactly at the timeout
      put(4'hF, 8'hFF, T - 1);
      chk("stale_early", 16'(stale), 16'h0);
      put(4'hF, 8'hFF, 1);
      chk("stale_at_T",  16'(stale), 16'h1);

      // basic scan 2,3,4,5
      fv_cnt = 0;
      dig(4'b0111, 8'h25);
      dig(4'b1011, 8'h0D);
      dig(4'b1101, 8'h99);
      dig(4'b1110, 8'h49);
      chk("scan_fv_cnt", 16'(fv_cnt), 16'd1);
      chk("scan_bcd",    bcd_out, 16'h2345);
      chk("scan_blank",  16'(blank_mask), 16'h0);
      chk("scan_stale",  16'(stale), 16'h0);

      // short glitch on digit 0 is never captured
      dig(4'b0111, 8'h1F);
      dig(4'b1011, 8'h9F);
      dig(4'b1101, 8'h03);
      put(4'b1110, 8'h01, S - 1);
      dig(4'b1110, 8'h09);
      chk("glitch_bcd", bcd_out, 16'h7109);

      // undecodable pattern on digit 2, then clear
      dig(4'b0111, 8'h03);
      dig(4'b1011, 8'h55);
      dig(4'b1101, 8'h03);
      dig(4'b1110, 8'h03);
      chk("inv_bcd",     bcd_out, 16'h0E00);
      chk("inv_seg_err", 16'(seg_err), 16'h1);
      err_clr = 1'b1;
      put(4'hF, 8'hFF, 1);
      err_clr = 1'b0;
      chk("errclr_seg_err", 16'(seg_err), 16'h0);

      // two selects low: error only; blank digit 1
      fv_cnt = 0;
      dig(4'b0111, 8'h03);
      dig(4'b1011, 8'h9F);
      put(4'b0011, 8'h25, 10);
      put(4'hF, 8'hFF, 2);
      chk("selerr_flag",  16'(sel_err), 16'h1);
      chk("selerr_no_fv", 16'(fv_cnt), 16'd0);
      dig(4'b1101, 8'hFF);
      dig(4'b1110, 8'h0D);
      chk("selerr_fv_cnt", 16'(fv_cnt), 16'd1);
      chk("blank_bcd",     bcd_out, 16'h01F3);
      chk("blank_mask",    16'(blank_mask), 16'h0002);
      err_clr = 1'b1;
      put(4'hF, 8'hFF, 1);
      err_clr = 1'b0;
      chk("errclr_sel_err", 16'(sel_err), 16'h0);

      // reset mid-frame discards partial captures
      dig(4'b0111, 8'h99);
      dig(4'b1011, 8'h49);
      rst = 1'b1;
      put(4'hF, 8'hFF, 2);
      rst = 1'b0;
      fv_cnt = 0;
      dig(4'b1101, 8'h41);
      dig(4'b1110, 8'h1F);
      chk("rstmid_no_fv", 16'(fv_cnt), 16'd0);
      chk("rstmid_bcd",   bcd_out, 16'hFFFF);
      dig(4'b0111, 8'h01);
      dig(4'b1011, 8'h09);
      chk("rstmid_fv_cnt", 16'(fv_cnt), 16'd1);
      chk("rstmid_bcd2",   bcd_out, 16'h8967);

      put(4'hF, 8'hFF, 3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
